// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: bus encodings, register map
// and reset values.
package irq_ctrl_pkg;

  localparam int         WORD_DATA_W = 32;
  localparam logic       ENABLE      = 1'b1;
  localparam logic       ENABLE_     = 1'b0;
  localparam logic       READ        = 1'b1;
  localparam logic       WRITE       = 1'b0;

  typedef enum logic [1:0] {
    IRQ_ADDR_PEND = 2'd0,
    IRQ_ADDR_MASK = 2'd1,
    IRQ_ADDR_MODE = 2'd2,
    IRQ_ADDR_VEC  = 2'd3
  } irq_addr_e;

  localparam int                     IRQ_VEC_VALID_LOC = 31;
  localparam logic [WORD_DATA_W-1:0] IRQ_MASK_RESET    = '1;

endpackage

// File: rtl/irq_ctrl_if.sv
// Peripheral bus bundle (cs_/as_/rw protocol) between the CPU side and the
// interrupt controller.
interface irq_ctrl_if;
  import irq_ctrl_pkg::*;

  logic                   cs_;
  logic                   as_;
  logic                   rw;
  logic [1:0]             addr;
  logic [WORD_DATA_W-1:0] wr_data;
  logic [WORD_DATA_W-1:0] rd_data;
  logic                   rdy_;

  modport master (
    output cs_, as_, rw, addr, wr_data,
    input  rd_data, rdy_
  );

  modport slave (
    input  cs_, as_, rw, addr, wr_data,
    output rd_data, rdy_
  );

endinterface

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: lowest-numbered active request wins.
module irq_prio_enc #(
  parameter int NUM_SRC   = 8,
  parameter int SRC_IDX_W = 3
) (
  input  logic [NUM_SRC-1:0]   req,
  output logic                 valid,
  output logic [SRC_IDX_W-1:0] index
);

  always_comb begin
    valid = |req;
    index = '0;
    // Scan downward so the last hit is the lowest index.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        index = SRC_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches level/edge requests into pending bits, masks
// them, drives cpu_irq and exposes a priority vector on the peripheral bus.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC   = 8,
  parameter int SRC_IDX_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  irq_ctrl_if.slave          bus,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               cpu_irq
);

  logic [NUM_SRC-1:0]     pending_reg, pending_next;
  logic [NUM_SRC-1:0]     mask_reg, mask_next;
  logic [NUM_SRC-1:0]     mode_reg, mode_next;
  logic [NUM_SRC-1:0]     prev_src_reg;
  logic [NUM_SRC-1:0]     active_reg;
  logic [NUM_SRC-1:0]     wr_bits;
  logic [WORD_DATA_W-1:0] rd_word;
  logic                   access, rd_en, wr_en;
  logic                   wr_pend, wr_mask, wr_mode;
  logic                   vec_valid;
  logic [SRC_IDX_W-1:0]   vec_index;
  logic                   unused_wr_data;

  assign access  = (bus.cs_ == ENABLE_) && (bus.as_ == ENABLE_);
  assign rd_en   = access && (bus.rw == READ);
  assign wr_en   = access && (bus.rw == WRITE);
  assign wr_pend = wr_en && (bus.addr == IRQ_ADDR_PEND);
  assign wr_mask = wr_en && (bus.addr == IRQ_ADDR_MASK);
  assign wr_mode = wr_en && (bus.addr == IRQ_ADDR_MODE);

  // Bits at or above NUM_SRC have no storage; writes to them are dropped.
  assign wr_bits        = bus.wr_data[NUM_SRC-1:0];
  assign unused_wr_data = ^bus.wr_data;

  assign mask_next = wr_mask ? wr_bits : mask_reg;
  assign mode_next = wr_mode ? wr_bits : mode_reg;

  // The mode in force this cycle decides the rule; a MODE write applies next cycle.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pend
      logic rise;
      assign rise = irq_src[gi] && !prev_src_reg[gi];
      assign pending_next[gi] = !mode_reg[gi]               ? irq_src[gi]  :
                                rise                        ? 1'b1         :
                                (wr_pend && wr_bits[gi])    ? 1'b0         :
                                                              pending_reg[gi];
    end
  endgenerate

  assign active_reg = pending_reg & ~mask_reg;

  irq_prio_enc #(
    .NUM_SRC   (NUM_SRC),
    .SRC_IDX_W (SRC_IDX_W)
  ) u_prio_enc (
    .req   (active_reg),
    .valid (vec_valid),
    .index (vec_index)
  );

  // Reads return pre-update register values.
  always_comb begin
    rd_word = '0;
    case (bus.addr)
      IRQ_ADDR_PEND: rd_word[NUM_SRC-1:0] = pending_reg;
      IRQ_ADDR_MASK: rd_word[NUM_SRC-1:0] = mask_reg;
      IRQ_ADDR_MODE: rd_word[NUM_SRC-1:0] = mode_reg;
      IRQ_ADDR_VEC: begin
        rd_word[IRQ_VEC_VALID_LOC] = vec_valid;
        rd_word[SRC_IDX_W-1:0]     = vec_index;
      end
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg  <= '0;
      mask_reg     <= IRQ_MASK_RESET[NUM_SRC-1:0];
      mode_reg     <= '0;
      prev_src_reg <= '0;
      bus.rd_data  <= '0;
      bus.rdy_     <= ~ENABLE_;
      cpu_irq      <= 1'b0;
    end else begin
      pending_reg  <= pending_next;
      mask_reg     <= mask_next;
      mode_reg     <= mode_next;
      prev_src_reg <= irq_src;
      bus.rd_data  <= rd_en ? rd_word : '0;
      bus.rdy_     <= access ? ENABLE_ : ~ENABLE_;
      cpu_irq      <= |(pending_next & ~mask_next);
    end
  end

endmodule
